// File: rtl/name_entry_pkg.sv
// rtl/name_entry_pkg.sv - scan-code constants, FSM encoding and name-char lookup for name entry
package name_entry_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    DRAW     = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Set-2 make codes for A-Z plus space
  function automatic logic is_name_char(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
      SC_SPACE: is_name_char = 1'b1;
      default:  is_name_char = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_prefix_filter.sv
// rtl/ps2_prefix_filter.sv - strips F0/E0 prefixed sequences, emits plain make codes
module ps2_prefix_filter
  import name_entry_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  output logic       make_valid,
  output logic [7:0] make_code
);

  logic brk;
  logic ext;
  logic is_prefix;

  assign is_prefix  = (scan_data == SC_BREAK) || (scan_data == SC_EXT);
  assign make_valid = scan_valid && !is_prefix && !brk && !ext;
  assign make_code  = scan_data;

  // The byte after any prefix is consumed here and clears both flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (clr) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (scan_valid) begin
      if (scan_data == SC_BREAK) begin
        brk <= 1'b1;
      end else if (scan_data == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/name_entry_ctrl.sv
// rtl/name_entry_ctrl.sv - high-score name entry FSM and character buffer fed by PS/2 make codes
module name_entry_ctrl
  import name_entry_pkg::*;
#(
  parameter int         MAX_LEN    = 5,
  parameter int         LEN_W      = 3,
  parameter logic [7:0] ENTER_CODE = SC_ENTER,
  parameter logic [7:0] BKSP_CODE  = SC_BKSP
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 go,
  input  logic [7:0]           scan_data,
  input  logic                 scan_valid,
  input  logic                 draw_ack,
  output logic                 draw_req,
  output logic [8*MAX_LEN-1:0] name_flat,
  output logic [LEN_W-1:0]     len,
  output logic                 entry_done
);

  state_t     state;
  state_t     next_state;
  logic       make_valid;
  logic [7:0] make_code;
  logic       op_add;
  logic       op_del;

  ps2_prefix_filter u_filter (
    .clk        (CLOCK_50),
    .reset      (reset),
    .clr        (go),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .make_valid (make_valid),
    .make_code  (make_code)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // go overrides every other event in every state
  always_comb begin
    next_state = state;
    op_add     = 1'b0;
    op_del     = 1'b0;
    if (go) begin
      next_state = WAIT_KEY;
    end else begin
      case (state)
        WAIT_KEY: begin
          if (make_valid) begin
            if (make_code == ENTER_CODE) begin
              if (len != '0) next_state = DONE;
            end else if (make_code == BKSP_CODE) begin
              if (len != '0) begin
                op_del     = 1'b1;
                next_state = DRAW;
              end
            end else if (is_name_char(make_code) && (len < LEN_W'(MAX_LEN))) begin
              op_add     = 1'b1;
              next_state = DRAW;
            end
          end
        end
        DRAW:    if (draw_ack) next_state = WAIT_KEY;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    entry_done = (state == DONE);
  end

  // draw_req trails the buffer write by one cycle so the drawer sees settled data
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      name_flat <= '0;
      len       <= '0;
      draw_req  <= 1'b0;
    end else if (go) begin
      name_flat <= '0;
      len       <= '0;
      draw_req  <= 1'b0;
    end else begin
      draw_req <= (state == DRAW) && !draw_ack;
      for (int k = 0; k < MAX_LEN; k++) begin
        if (op_add && (len == LEN_W'(k)))   name_flat[8*k +: 8] <= make_code;
        if (op_del && (len == LEN_W'(k+1))) name_flat[8*k +: 8] <= 8'h00;
      end
      if (op_add)      len <= len + 1'b1;
      else if (op_del) len <= len - 1'b1;
    end
  end

endmodule

// File: tb/tb_name_entry_ctrl.sv
// tb/tb_name_entry_ctrl.sv - directed self-checking bench for name_entry_ctrl
module tb_name_entry_ctrl;
  import name_entry_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  scan_data;
  logic        scan_valid;
  logic        draw_ack;
  logic        draw_req;
  logic [39:0] name_flat;
  logic [2:0]  len;
  logic        entry_done;

  int errors = 0;
  int checks = 0;
  int draws  = 0;
  int base;
  logic prev_req = 1'b0;

  name_entry_ctrl dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .go         (go),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .draw_ack   (draw_ack),
    .draw_req   (draw_req),
    .name_flat  (name_flat),
    .len        (len),
    .entry_done (entry_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (draw_req && !prev_req) draws = draws + 1;
    prev_req = draw_req;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_data  = b;
    scan_valid = 1'b1;
    cyc();
    scan_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    cyc();
    go = 1'b0;
  endtask

  task automatic ack_draw(input string tag);
    cyc();
    chk({tag, "_req_high"}, 64'(draw_req), 64'd1);
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    chk({tag, "_req_low"}, 64'(draw_req), 64'd0);
    chk({tag, "_state"}, 64'(dut.state), 64'(WAIT_KEY));
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; scan_data = 8'h00; scan_valid = 1'b0; draw_ack = 1'b0;
    cyc(); cyc();
    chk("rst_len", 64'(len), 64'd0);
    chk("rst_name", 64'(name_flat), 64'd0);
    chk("rst_req", 64'(draw_req), 64'd0);
    chk("rst_done", 64'(entry_done), 64'd0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    reset = 1'b0;
    cyc();

    // 1: IDLE ignores makes; go, then 1C, F0 1C
    send(8'h1C);
    chk("idle_len", 64'(len), 64'd0);
    pulse_go();
    chk("go_state", 64'(dut.state), 64'(WAIT_KEY));
    base = draws;
    send(8'h1C);
    chk("t1_len", 64'(len), 64'd1);
    chk("t1_name", 64'(name_flat), 64'h1C);
    chk("t1_req_lag", 64'(draw_req), 64'd0);
    ack_draw("t1");
    send(8'hF0); send(8'h1C);
    chk("t1_brk_len", 64'(len), 64'd1);
    cyc();
    chk("t1_draws", 64'(draws - base), 64'd1);

    // 2: extended make and break sequences filtered
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    cyc();
    chk("t2_len", 64'(len), 64'd1);
    chk("t2_name", 64'(name_flat), 64'h1C);
    chk("t2_req", 64'(draw_req), 64'd0);
    chk("t2_brk", 64'(dut.u_filter.brk), 64'd0);
    chk("t2_ext", 64'(dut.u_filter.ext), 64'd0);

    // 3: type A,B with breaks, then backspace
    pulse_go();
    base = draws;
    send(8'h1C); ack_draw("t3a"); send(8'hF0); send(8'h1C);
    send(8'h32); ack_draw("t3b"); send(8'hF0); send(8'h32);
    chk("t3_len2", 64'(len), 64'd2);
    chk("t3_name2", 64'(name_flat), 64'h321C);
    send(8'h66);
    chk("t3_len", 64'(len), 64'd1);
    chk("t3_name", 64'(name_flat), 64'h1C);
    ack_draw("t3c");
    chk("t3_draws", 64'(draws - base), 64'd3);

    // 4: empty enter ignored, saturation at 5, enter latches done
    pulse_go();
    send(8'h5A);
    chk("t4_enter0_state", 64'(dut.state), 64'(WAIT_KEY));
    chk("t4_enter0_done", 64'(entry_done), 64'd0);
    send(8'h1C); ack_draw("t4a");
    send(8'h32); ack_draw("t4b");
    send(8'h21); ack_draw("t4c");
    send(8'h23); ack_draw("t4d");
    send(8'h24); ack_draw("t4e");
    base = draws;
    send(8'h2B);
    cyc();
    chk("t4_sat_len", 64'(len), 64'd5);
    chk("t4_sat_name", 64'(name_flat), 64'h242321321C);
    chk("t4_sat_req", 64'(draw_req), 64'd0);
    send(8'h66 + 8'h00 == 8'h66 ? 8'h4D : 8'h4D);
    chk("t4_nonch_len", 64'(len), 64'd5);
    send(8'h5A);
    chk("t4_done", 64'(entry_done), 64'd1);
    send(8'h66);
    cyc(); cyc();
    chk("t4_frozen_len", 64'(len), 64'd5);
    chk("t4_done_hold", 64'(entry_done), 64'd1);
    chk("t4_no_draw", 64'(draws - base), 64'd0);
    pulse_go();
    chk("t4_go_done", 64'(entry_done), 64'd0);
    chk("t4_go_len", 64'(len), 64'd0);

    // 5: letter during DRAW dropped; go beats simultaneous scan byte
    send(8'h1C);
    send(8'h32);
    chk("t5_drop_len", 64'(len), 64'd1);
    chk("t5_req", 64'(draw_req), 64'd1);
    go = 1'b1; scan_data = 8'h33; scan_valid = 1'b1;
    cyc();
    go = 1'b0; scan_valid = 1'b0;
    chk("t5_go_len", 64'(len), 64'd0);
    chk("t5_go_name", 64'(name_flat), 64'd0);
    chk("t5_go_state", 64'(dut.state), 64'(WAIT_KEY));
    chk("t5_go_req", 64'(draw_req), 64'd0);

    // 6: asynchronous reset mid-DRAW
    send(8'h1C);
    cyc();
    chk("t6_pre_req", 64'(draw_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_req", 64'(draw_req), 64'd0);
    chk("t6_len", 64'(len), 64'd0);
    chk("t6_name", 64'(name_flat), 64'd0);
    chk("t6_state", 64'(dut.state), 64'(IDLE));
    cyc();
    reset = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
